// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and constants for the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned TAGW_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Quotient reported for a divide by zero.
  localparam logic [WIDTH_DEF-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on {P,Q}.
module muldiv_step
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] pq,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] pq_nxt
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;

  // Compute the next accumulator value for the selected operation.
  always_comb begin
    p    = pq[2*WIDTH-1:WIDTH];
    q    = pq[WIDTH-1:0];
    // MUL: conditional add keeps the carry so the right shift cannot lose it.
    sum  = {1'b0, p} + (q[0] ? {1'b0, b} : '0);
    // DIV: partial remainder after the left shift needs one extra bit.
    rem  = {p, q[WIDTH-1]};
    diff = WIDTH'(rem - {1'b0, b});
    if (op == OP_MUL) begin
      pq_nxt = {sum, q[WIDTH-1:1]};
    end else if (rem >= {1'b0, b}) begin
      pq_nxt = {diff, q[WIDTH-2:0], 1'b1};
    end else begin
      pq_nxt = {rem[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide unit for the execute stage.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned TAGW  = TAGW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAGW-1:0]  rdIn,
  input  logic [1:0]       wbIn,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz,
  output logic [TAGW-1:0]  rdOut,
  output logic [1:0]       wbOut
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [1:0]       wb_q, wb_d;
  logic [TAGW-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [1:0]       wbo_q, wbo_d;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .pq     (acc_q),
    .b      (b_q),
    .pq_nxt (acc_step)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    wbo_d   = 2'b00;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            op_d    = op;
            b_d     = b;
            wb_d    = wbIn;
            rd_d    = rdIn;
            count_d = CW'(WIDTH);
            acc_d   = {WIDTH'(0), a};
            if (op == OP_DIV && b == '0) begin
              state_d = S_DONE;
              hi_d    = a;
              lo_d    = WIDTH'(DZ_QUOT);
              dz_d    = 1'b1;
              done_d  = 1'b1;
              wbo_d   = wbIn;
            end else begin
              state_d = S_RUN;
              dz_d    = 1'b0;
            end
          end
        end
        S_RUN: begin
          acc_d   = acc_step;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = S_DONE;
            hi_d    = acc_step[AW-1:WIDTH];
            lo_d    = acc_step[WIDTH-1:0];
            done_d  = 1'b1;
            wbo_d   = wb_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      wb_q    <= '0;
      rd_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wbo_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wbo_q   <= wbo_d;
    end
  end

  // Upstream hold: busy, or a request is being taken this cycle.
  assign stall = (state_q == S_RUN) |
                 (((state_q == S_IDLE) | (state_q == S_DONE)) & start);

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign dz    = dz_q;
  assign rdOut = rd_q;
  assign wbOut = wbo_q;

endmodule
